// File: rtl/fsk_tx_sequencer.sv
// Packet sequencer for the FSK modulator: oscillator warmup, preamble, access address,
// payload and tail, one bit per SPS clocks. Define FSK_WHITEN_EN to whiten payload bits.
module fsk_tx_sequencer #(
  parameter int SPS        = 8,
  parameter int WARMUP_CYC = 64,
  parameter int TAIL_SYM   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  len,
  input  logic [31:0] access_addr,
  input  logic [5:0]  chan,
  output logic [7:0]  buf_addr,
  input  logic [7:0]  buf_data,
  output logic        osc_en,
  output logic        mod_en,
  output logic        mod_bit,
  output logic        bit_strobe,
  output logic        busy,
  output logic        done
);
  localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int WC_W = $clog2(WARMUP_CYC + 1);
  localparam logic [SC_W-1:0] SYM_LAST  = SC_W'(SPS - 1);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_CYC - 1);
  localparam logic [7:0]      TAIL_LAST = 8'(TAIL_SYM - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WARMUP   = 3'd1,
    PREAMBLE = 3'd2,
    ACCESS   = 3'd3,
    PAYLOAD  = 3'd4,
    TAIL     = 3'd5
  } state_t;

  state_t          state_r;
  logic [7:0]      len_r;
  logic [31:0]     aa_r;
  logic [5:0]      chan_r;
  logic [SC_W-1:0] sym_cnt_r;
  logic [WC_W-1:0] warm_cnt_r;
  logic [7:0]      bit_idx_r;
  logic [7:0]      byte_idx_r;
  logic [7:0]      byte_r;

  logic       sym_end_s;
  logic       last_byte_s;
  logic [4:0] next_idx_s;
  logic       first_bit_s;
  logic       new_byte_bit_s;
  logic       next_bit_s;

  assign sym_end_s   = (sym_cnt_r == SYM_LAST);
  assign last_byte_s = (({1'b0, byte_idx_r} + 9'd1) == {1'b0, len_r});
  assign next_idx_s  = bit_idx_r[4:0] + 5'd1;

`ifdef FSK_WHITEN_EN
  logic [6:0] lfsr_r;
  logic [6:0] seed_s;

  // x^7+x^4+1 whitening LFSR, bit index = register position, output taken from position 6
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5], s[4], s[3] ^ s[6], s[2], s[1], s[0], s[6]};
  endfunction

  assign seed_s         = {chan_r[0], chan_r[1], chan_r[2], chan_r[3], chan_r[4], chan_r[5], 1'b1};
  assign first_bit_s    = buf_data[0] ^ seed_s[6];
  assign new_byte_bit_s = buf_data[0] ^ lfsr_r[6];
  assign next_bit_s     = byte_r[next_idx_s[2:0]] ^ lfsr_r[6];
`else
  logic chan_unused_s;
  assign chan_unused_s  = ^chan_r;
  assign first_bit_s    = buf_data[0];
  assign new_byte_bit_s = buf_data[0];
  assign next_bit_s     = byte_r[next_idx_s[2:0]];
`endif

  // Sequencer FSM, counters and registered modulator-side outputs
  always_ff @(posedge clk) begin
    if (rst || (abort && (state_r != IDLE))) begin
      state_r    <= IDLE;
      len_r      <= 8'd0;
      aa_r       <= 32'd0;
      chan_r     <= 6'd0;
      sym_cnt_r  <= '0;
      warm_cnt_r <= '0;
      bit_idx_r  <= 8'd0;
      byte_idx_r <= 8'd0;
      byte_r     <= 8'd0;
      buf_addr   <= 8'd0;
      osc_en     <= 1'b0;
      mod_en     <= 1'b0;
      mod_bit    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef FSK_WHITEN_EN
      lfsr_r     <= 7'd0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      if ((state_r == IDLE) || (state_r == WARMUP) || sym_end_s) sym_cnt_r <= '0;
      else sym_cnt_r <= sym_cnt_r + 1'b1;

      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            len_r      <= len;
            aa_r       <= access_addr;
            chan_r     <= chan;
            warm_cnt_r <= '0;
            busy       <= 1'b1;
            osc_en     <= 1'b1;
            state_r    <= WARMUP;
          end
        end
        WARMUP: begin
          if (warm_cnt_r == WARM_LAST) begin
            state_r    <= PREAMBLE;
            mod_en     <= 1'b1;
            bit_strobe <= 1'b1;
            mod_bit    <= aa_r[0];
            bit_idx_r  <= 8'd0;
          end else begin
            warm_cnt_r <= warm_cnt_r + 1'b1;
          end
        end
        // preamble bit i alternates and starts with aa[0], so bit 7 differs from aa[0]
        PREAMBLE: begin
          if (sym_end_s) begin
            bit_strobe <= 1'b1;
            if (bit_idx_r == 8'd7) begin
              state_r   <= ACCESS;
              bit_idx_r <= 8'd0;
              mod_bit   <= aa_r[0];
            end else begin
              bit_idx_r <= bit_idx_r + 8'd1;
              mod_bit   <= ~bit_idx_r[0] ^ aa_r[0];
            end
          end
        end
        ACCESS: begin
          if (sym_end_s) begin
            bit_strobe <= 1'b1;
            if (bit_idx_r == 8'd31) begin
              bit_idx_r  <= 8'd0;
              byte_idx_r <= 8'd0;
              if (len_r == 8'd0) begin
                state_r <= TAIL;
                mod_bit <= 1'b0;
              end else begin
                state_r <= PAYLOAD;
                byte_r  <= buf_data;
                mod_bit <= first_bit_s;
`ifdef FSK_WHITEN_EN
                lfsr_r  <= lfsr_step(seed_s);
`endif
              end
            end else begin
              bit_idx_r <= bit_idx_r + 8'd1;
              mod_bit   <= aa_r[next_idx_s];
              if (bit_idx_r == 8'd30) buf_addr <= 8'd0;
            end
          end
        end
        PAYLOAD: begin
          if (sym_end_s) begin
            bit_strobe <= 1'b1;
            if (bit_idx_r == 8'd7) begin
              bit_idx_r <= 8'd0;
              if (last_byte_s) begin
                state_r <= TAIL;
                mod_bit <= 1'b0;
              end else begin
                byte_idx_r <= byte_idx_r + 8'd1;
                byte_r     <= buf_data;
                mod_bit    <= new_byte_bit_s;
`ifdef FSK_WHITEN_EN
                lfsr_r     <= lfsr_step(lfsr_r);
`endif
              end
            end else begin
              bit_idx_r <= bit_idx_r + 8'd1;
              mod_bit   <= next_bit_s;
`ifdef FSK_WHITEN_EN
              lfsr_r    <= lfsr_step(lfsr_r);
`endif
              // next byte is requested for the whole of bit 7 so buf_data settles first
              if ((bit_idx_r == 8'd6) && !last_byte_s) buf_addr <= byte_idx_r + 8'd1;
            end
          end
        end
        TAIL: begin
          if (sym_end_s) begin
            if (bit_idx_r == TAIL_LAST) begin
              state_r   <= IDLE;
              osc_en    <= 1'b0;
              mod_en    <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              mod_bit   <= 1'b0;
              bit_idx_r <= 8'd0;
            end else begin
              bit_strobe <= 1'b1;
              bit_idx_r  <= bit_idx_r + 8'd1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Randomized scoreboard bench for fsk_tx_sequencer: a packet-level model queues the
// expected symbol stream and busy length; a monitor checks them as the DUT emits symbols.
`timescale 1ns/1ps
module tb_fsk_tx_sequencer;
  localparam int SPS        = 8;
  localparam int WARMUP_CYC = 64;
  localparam int TAIL_SYM   = 4;
`ifdef FSK_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  len;
  logic [31:0] access_addr;
  logic [5:0]  chan;
  logic [7:0]  buf_addr, buf_data;
  logic        osc_en, mod_en, mod_bit, bit_strobe, busy, done;
  logic [7:0]  buf_mem [256];

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_bits [$];
  int   exp_busy [$];
  int   exp_last [$];
  int   busy_cnt = 0, sym_len = 0, strobe_cnt = 0, done_cnt = 0;
  logic in_sym = 1'b0, cur_bit = 1'b0, sym_bad = 1'b0, e_bit;
  logic addr_watch = 1'b0, addr_moved = 1'b0;

  always #5 clk = ~clk;

  fsk_tx_sequencer #(.SPS(SPS), .WARMUP_CYC(WARMUP_CYC), .TAIL_SYM(TAIL_SYM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .access_addr(access_addr), .chan(chan), .buf_addr(buf_addr), .buf_data(buf_data),
    .osc_en(osc_en), .mod_en(mod_en), .mod_bit(mod_bit), .bit_strobe(bit_strobe),
    .busy(busy), .done(done)
  );

  // packet byte buffer with one clock of read latency
  always @(posedge clk) buf_data <= buf_mem[buf_addr];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_bits.delete();
    exp_busy.delete();
    exp_last.delete();
    busy_cnt = 0; strobe_cnt = 0; in_sym = 1'b0; sym_bad = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_osc_en"},     {31'd0, osc_en},     32'd0);
    check_val({tag, "_mod_en"},     {31'd0, mod_en},     32'd0);
    check_val({tag, "_mod_bit"},    {31'd0, mod_bit},    32'd0);
    check_val({tag, "_bit_strobe"}, {31'd0, bit_strobe}, 32'd0);
    check_val({tag, "_busy"},       {31'd0, busy},       32'd0);
    check_val({tag, "_done"},       {31'd0, done},       32'd0);
    check_val({tag, "_buf_addr"},   {24'd0, buf_addr},   32'd0);
  endtask

  // Reference: the on-air bit sequence of a packet, from the field layout
  task automatic expect_packet(input logic [31:0] aa, input int l, input logic [5:0] ch);
    logic [7:0] pre;
    logic [6:0] w;
    logic       b, o;
    pre = aa[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++) exp_bits.push_back(pre[i]);
    for (int i = 0; i < 32; i++) exp_bits.push_back(aa[i]);
    w[0] = 1'b1;
    for (int i = 0; i < 6; i++) w[i + 1] = ch[5 - i];
    for (int k = 0; k < l; k++) begin
      for (int i = 0; i < 8; i++) begin
        b = buf_mem[k][i];
        o = w[6];
        w = {w[5:0], o};
        w[4] = w[4] ^ o;
        exp_bits.push_back(b ^ (o & WHITEN));
      end
    end
    for (int i = 0; i < TAIL_SYM; i++) exp_bits.push_back(1'b0);
    exp_busy.push_back(WARMUP_CYC + (8 + 32 + 8 * l + TAIL_SYM) * SPS);
    exp_last.push_back((l == 0) ? 0 : l - 1);
  endtask

  task automatic launch(input string tag, input logic [31:0] aa, input int l, input logic [5:0] ch);
    expect_packet(aa, l, ch);
    access_addr = aa; len = 8'(l); chan = ch; start = 1'b1;
    tick();
    start = 1'b0;
    access_addr = $urandom(); len = 8'($urandom()); chan = 6'($urandom());
    check_val({tag, "_busy_on_start"}, {31'd0, busy},   32'd1);
    check_val({tag, "_osc_on_start"},  {31'd0, osc_en}, 32'd1);
    check_val({tag, "_mod_in_warmup"}, {31'd0, mod_en}, 32'd0);
  endtask

  task automatic run_packet(input string tag, input logic [31:0] aa, input int l,
                            input logic [5:0] ch, input bit poke);
    int d0, budget;
    d0 = done_cnt;
    budget = WARMUP_CYC + (44 + 8 * l) * SPS + 20;
    launch(tag, aa, l, ch);
    for (int c = 0; (c < budget) && (done_cnt == d0); c++) begin
      start = (poke && (c == 300));
      tick();
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, done_cnt, d0 + 1);
    if (done_cnt == d0) begin
      rst = 1'b1; tick(); flush(); rst = 1'b0; tick();
    end
    tick(); tick();
    check_val({tag, "_done_once"}, done_cnt, d0 + 1);
  endtask

  task automatic wait_strobes(input string tag, input int n);
    for (int c = 0; (c < 2000) && (strobe_cnt < n); c++) tick();
    check_val({tag, "_reached"}, {31'd0, strobe_cnt >= n}, 32'd1);
  endtask

  // Monitor: pops the expected bit at every symbol start and checks symbol timing/completion
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (addr_watch && busy && (buf_addr != 8'd0)) addr_moved = 1'b1;
    if (bit_strobe) begin
      if (in_sym) begin
        check_val("symbol_length", sym_len, SPS);
        check_val("symbol_stable", {31'd0, sym_bad}, 32'd0);
      end
      check_val("mod_en_at_strobe", {31'd0, mod_en}, 32'd1);
      if (exp_bits.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_symbol: symbol %0d present, none expected", strobe_cnt);
      end else begin
        e_bit = exp_bits.pop_front();
        check_val($sformatf("mod_bit_sym%0d", strobe_cnt), {31'd0, mod_bit}, {31'd0, e_bit});
      end
      strobe_cnt++;
      in_sym = 1'b1; sym_len = 1; cur_bit = mod_bit; sym_bad = 1'b0;
    end else if (in_sym && mod_en) begin
      sym_len++;
      if (mod_bit !== cur_bit) sym_bad = 1'b1;
    end
    if (done) begin
      check_val("done_busy_low", {31'd0, busy},   32'd0);
      check_val("done_osc_low",  {31'd0, osc_en}, 32'd0);
      check_val("done_mod_low",  {31'd0, mod_en}, 32'd0);
      if (in_sym) check_val("last_symbol_length", sym_len, SPS);
      check_val("bits_left", exp_bits.size(), 32'd0);
      if (exp_busy.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done, expected none");
      end else begin
        check_val("busy_cycles", busy_cnt, exp_busy.pop_front());
        check_val("final_buf_addr", {24'd0, buf_addr}, exp_last.pop_front());
      end
      done_cnt++;
      busy_cnt = 0; strobe_cnt = 0; in_sym = 1'b0;
    end
  end

  initial begin
    int d0, l;
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 8'd0; access_addr = 32'd0; chan = 6'd0;
    for (int i = 0; i < 256; i++) buf_mem[i] = 8'($urandom());
    tick(); tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("after_reset");

    buf_mem[0] = 8'h01; buf_mem[1] = 8'hF0;
    run_packet("basic", 32'h8E89BED6, 2, 6'd0, 1'b1);
    run_packet("pre55", 32'h00000001, 1, 6'($urandom()), 1'b0);

    // reset held for three clocks in the middle of the payload
    d0 = done_cnt;
    launch("rst_mid", $urandom(), 3, 6'($urandom()));
    wait_strobes("rst_mid", 43);
    rst = 1'b1;
    tick();
    check_idle("rst_mid_payload");
    flush();
    tick(); tick();
    rst = 1'b0;
    tick();
    check_idle("rst_release");
    check_val("rst_no_done", done_cnt, d0);

    addr_watch = 1'b1; addr_moved = 1'b0;
    run_packet("len0", $urandom(), 0, 6'($urandom()), 1'b0);
    addr_watch = 1'b0;
    check_val("len0_addr_stays_0", {31'd0, addr_moved}, 32'd0);

    // abort during access-address bit 10, then a fresh packet
    d0 = done_cnt;
    launch("abort", $urandom(), 2, 6'($urandom()));
    wait_strobes("abort", 19);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_access10");
    flush();
    repeat (5) tick();
    check_val("abort_no_done", done_cnt, d0);
    buf_mem[0] = 8'($urandom()); buf_mem[1] = 8'($urandom()); buf_mem[2] = 8'($urandom());
    run_packet("after_abort", $urandom(), 3, 6'($urandom()), 1'b0);

    // abort alone in IDLE must not disturb the held buffer address
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_idle_hold", {24'd0, buf_addr}, 32'd2);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_val("start_abort_idle_busy", {31'd0, busy},   32'd0);
    check_val("start_abort_idle_osc",  {31'd0, osc_en}, 32'd0);

    for (int r = 0; r < 4; r++) begin
      l = $urandom_range(1, 6);
      for (int k = 0; k < l; k++) buf_mem[k] = 8'($urandom());
      run_packet($sformatf("rand%0d", r), $urandom(), l, 6'($urandom()), 1'b0);
    end

    for (int k = 0; k < 256; k++) buf_mem[k] = 8'($urandom());
    run_packet("len255", $urandom(), 255, 6'($urandom()), 1'b0);

    buf_mem[0] = 8'h00;
    run_packet("chan37", $urandom(), 1, 6'd37, 1'b0);

    // rst and abort together mid-packet
    launch("rst_abort", $urandom(), 1, 6'($urandom()));
    wait_strobes("rst_abort", 5);
    rst = 1'b1; abort = 1'b1;
    tick();
    check_idle("rst_abort");
    flush();
    rst = 1'b0; abort = 1'b0;
    tick();
    check_idle("rst_abort_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
